// File: rtl/pipe_hazard_ctrl_if.sv
// Stall/flush control bundle between the datapath (master) and pipe_hazard_ctrl (slave).
interface pipe_hazard_ctrl_if #(
   parameter int unsigned NUM_STAGES = 6,
   parameter int unsigned CYC_W      = 6,
   parameter int unsigned CNT_W      = 16
);
   logic                  stallreq_from_if_i;
   logic                  stallreq_from_id_i;
   logic                  stallreq_from_mem_i;
   logic                  ex_start_i;
   logic [CYC_W-1:0]      ex_cycles_i;
   logic                  br_flush_i;
   logic                  exc_flush_i;
   logic [NUM_STAGES-1:0] stall_o;
   logic [NUM_STAGES-1:0] flush_o;
   logic                  ex_busy_o;
   logic                  ex_done_o;
   logic [CNT_W-1:0]      stall_cycles_o;
   logic [CNT_W-1:0]      flush_count_o;

   modport master (
      output stallreq_from_if_i, stallreq_from_id_i, stallreq_from_mem_i,
      output ex_start_i, ex_cycles_i, br_flush_i, exc_flush_i,
      input  stall_o, flush_o, ex_busy_o, ex_done_o, stall_cycles_o, flush_count_o
   );

   modport slave (
      input  stallreq_from_if_i, stallreq_from_id_i, stallreq_from_mem_i,
      input  ex_start_i, ex_cycles_i, br_flush_i, exc_flush_i,
      output stall_o, flush_o, ex_busy_o, ex_done_o, stall_cycles_o, flush_count_o
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: thermometer stall merge, multi-cycle EX FSM, deferred branch flush.
// Optional perf counters are built when PIPE_HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
   parameter int unsigned          NUM_STAGES = 6,
   parameter int unsigned          IF_DEPTH   = 3,
   parameter int unsigned          ID_DEPTH   = 3,
   parameter int unsigned          EX_DEPTH   = 4,
   parameter int unsigned          MEM_DEPTH  = 5,
   parameter logic [NUM_STAGES-1:0] BR_FLUSH  = 6'b000110,
   parameter int unsigned          CYC_W      = 6,
   parameter int unsigned          CNT_W      = 16
) (
   input logic               clk_i,
   input logic               rst_i,
   pipe_hazard_ctrl_if.slave bus
);

   typedef enum logic [0:0] {StIdle, StBusy} ex_state_e;

   ex_state_e             state_q, state_d;
   logic [CYC_W-1:0]      cnt_q, cnt_d;
   logic                  pend_q, pend_d;

   logic                  ex_long;
   logic                  ex_stall;
   logic                  br_req;
   logic [NUM_STAGES-1:0] stall_raw;
   logic [NUM_STAGES-1:0] stall;
   logic [NUM_STAGES-1:0] flush;
   logic                  ex_busy;
   logic                  ex_done;

   assign ex_long  = (state_q == StIdle) && bus.ex_start_i && (bus.ex_cycles_i >= CYC_W'(2));
   assign ex_stall = (state_q == StBusy) || ex_long;
   assign br_req   = bus.br_flush_i || pend_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      if (bus.exc_flush_i) begin
         state_d = StIdle;
         cnt_d   = '0;
         pend_d  = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (ex_long) begin
                  state_d = StBusy;
                  cnt_d   = bus.ex_cycles_i - CYC_W'(2);
               end
            end
            StBusy: begin
               if (cnt_q == '0) state_d = StIdle;
               else             cnt_d   = cnt_q - CYC_W'(1);
            end
            default: state_d = StIdle;
         endcase
         // A branch seen under EX stall is held until the first unstalled cycle.
         pend_d = ex_stall ? br_req : 1'b0;
      end
   end

   always_comb begin
      stall_raw = '0;
      for (int unsigned k = 0; k < NUM_STAGES; k++) begin
         if ((bus.stallreq_from_if_i  && k < IF_DEPTH)  ||
             (bus.stallreq_from_id_i  && k < ID_DEPTH)  ||
             (bus.stallreq_from_mem_i && k < MEM_DEPTH) ||
             (ex_stall                && k < EX_DEPTH)) begin
            stall_raw[k] = 1'b1;
         end
      end

      flush = '0;
      if (rst_i)                       flush = '0;
      else if (bus.exc_flush_i)        flush = '1;
      else if (!ex_stall && br_req)    flush = BR_FLUSH;

      stall = '0;
      if (!rst_i && !bus.exc_flush_i)  stall = stall_raw & ~flush;

      ex_busy = !rst_i && (state_q == StBusy);
      ex_done = !rst_i &&
                (((state_q == StIdle) && bus.ex_start_i && (bus.ex_cycles_i < CYC_W'(2))) ||
                 ((state_q == StBusy) && (cnt_q == '0)));
   end

   assign bus.stall_o   = stall;
   assign bus.flush_o   = flush;
   assign bus.ex_busy_o = ex_busy;
   assign bus.ex_done_o = ex_done;

`ifdef PIPE_HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if ((stall != '0) && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if ((flush != '0) && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign bus.stall_cycles_o = stall_cnt_q;
   assign bus.flush_count_o  = flush_cnt_q;
`else
   assign bus.stall_cycles_o = CNT_W'(0);
   assign bus.flush_count_o  = CNT_W'(0);
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic vs a cycle model.
module tb_pipe_hazard_ctrl;

   localparam int IF_D = 3, ID_D = 3, EX_D = 4, MEM_D = 5, NS = 6;

   logic clk = 1'b0;
   logic rst;

   pipe_hazard_ctrl_if hif ();

   pipe_hazard_ctrl dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (hif.slave)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Model: remaining EX stall cycles (incl. current), pending branch, perf totals.
   int   m_left = 0;
   bit   m_pend = 0;
   int   m_scnt = 0;
   int   m_fcnt = 0;
   bit   m_busy, m_start_long, m_ex_stall;

   logic [5:0]  exp_stall, exp_flush;
   logic        exp_busy, exp_done;
   logic [15:0] exp_scnt, exp_fcnt;

   task automatic drive_idle();
      hif.stallreq_from_if_i  = 1'b0;
      hif.stallreq_from_id_i  = 1'b0;
      hif.stallreq_from_mem_i = 1'b0;
      hif.ex_start_i          = 1'b0;
      hif.ex_cycles_i         = '0;
      hif.br_flush_i          = 1'b0;
      hif.exc_flush_i         = 1'b0;
   endtask

   task automatic eval_model();
      int d;
      m_busy       = (m_left > 0);
      m_start_long = !m_busy && hif.ex_start_i && (int'(hif.ex_cycles_i) >= 2);
      m_ex_stall   = m_busy || m_start_long;
      d = 0;
      if (hif.stallreq_from_if_i  && IF_D  > d) d = IF_D;
      if (hif.stallreq_from_id_i  && ID_D  > d) d = ID_D;
      if (hif.stallreq_from_mem_i && MEM_D > d) d = MEM_D;
      if (m_ex_stall              && EX_D  > d) d = EX_D;
      if (d > NS) d = NS;
      exp_stall = '0;
      for (int k = 0; k < NS; k++) exp_stall[k] = (k < d);
      if (hif.exc_flush_i)                        exp_flush = 6'b111111;
      else if (!m_ex_stall && (hif.br_flush_i || m_pend)) exp_flush = 6'b000110;
      else                                        exp_flush = 6'b000000;
      exp_stall = hif.exc_flush_i ? 6'b0 : (exp_stall & ~exp_flush);
      exp_busy  = m_busy;
      exp_done  = (!m_busy && hif.ex_start_i && (int'(hif.ex_cycles_i) < 2)) || (m_left == 1);
      exp_scnt  = 16'(m_scnt);
      exp_fcnt  = 16'(m_fcnt);
      if (rst) begin
         exp_stall = '0;
         exp_flush = '0;
         exp_busy  = 1'b0;
         exp_done  = 1'b0;
      end
   endtask

   task automatic commit_model();
      if (rst) begin
         m_left = 0;
         m_pend = 0;
         m_scnt = 0;
         m_fcnt = 0;
      end else begin
`ifdef PIPE_HAZARD_PERF_CNT_EN
         if (exp_stall != 0 && m_scnt < 65535) m_scnt++;
         if (exp_flush != 0 && m_fcnt < 65535) m_fcnt++;
`endif
         if (hif.exc_flush_i) begin
            m_left = 0;
            m_pend = 0;
         end else begin
            m_pend = m_ex_stall ? (m_pend | hif.br_flush_i) : 1'b0;
            if (m_busy)            m_left--;
            else if (m_start_long) m_left = int'(hif.ex_cycles_i) - 1;
         end
      end
   endtask

   task automatic sample();
      @(negedge clk);
      eval_model();
   endtask

   task automatic advance();
      commit_model();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      hif.stallreq_from_if_i  = 1'b1;
      hif.stallreq_from_id_i  = 1'b1;
      hif.stallreq_from_mem_i = 1'b1;
      hif.ex_start_i          = 1'b1;
      hif.ex_cycles_i         = 6'd4;
      hif.br_flush_i          = 1'b1;
      hif.exc_flush_i         = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sample();
         n_checks++;
         if (hif.stall_o !== 6'b0) $display("FAIL reset_stall cyc %0d: got %b want 000000", i, hif.stall_o);
         else n_pass++;
         n_checks++;
         if (hif.flush_o !== 6'b0) $display("FAIL reset_flush cyc %0d: got %b want 000000", i, hif.flush_o);
         else n_pass++;
         n_checks++;
         if (hif.ex_busy_o !== 1'b0) $display("FAIL reset_busy cyc %0d: got %b want 0", i, hif.ex_busy_o);
         else n_pass++;
         advance();
      end
      rst = 1'b0;
      drive_idle();
      sample();
      n_checks++;
      if (hif.stall_cycles_o !== 16'd0 || hif.flush_count_o !== 16'd0)
         $display("FAIL reset_counters: got %0d/%0d want 0/0", hif.stall_cycles_o, hif.flush_count_o);
      else n_pass++;
      advance();
   endtask

   task automatic test_id_mem_stall();
      logic [5:0] want [3] = '{6'b000111, 6'b011111, 6'b000000};
      for (int i = 0; i < 3; i++) begin
         hif.stallreq_from_id_i  = (i < 2);
         hif.stallreq_from_mem_i = (i == 1);
         sample();
         n_checks++;
         if (hif.stall_o !== want[i] || hif.stall_o !== exp_stall)
            $display("FAIL id_mem_stall step %0d: got %b want %b", i, hif.stall_o, want[i]);
         else n_pass++;
         advance();
      end
      drive_idle();
   endtask

   task automatic test_ex_multi();
      hif.ex_start_i  = 1'b1;
      hif.ex_cycles_i = 6'd4;
      for (int k = 0; k < 5; k++) begin
         logic [5:0] ws;
         logic       wb, wd;
         ws = (k < 4) ? 6'b001111 : 6'b000000;
         wb = (k >= 1 && k <= 3);
         wd = (k == 3);
         sample();
         n_checks++;
         if (hif.stall_o !== ws) $display("FAIL ex4_stall t+%0d: got %b want %b", k, hif.stall_o, ws);
         else n_pass++;
         n_checks++;
         if (hif.ex_busy_o !== wb) $display("FAIL ex4_busy t+%0d: got %b want %b", k, hif.ex_busy_o, wb);
         else n_pass++;
         n_checks++;
         if (hif.ex_done_o !== wd) $display("FAIL ex4_done t+%0d: got %b want %b", k, hif.ex_done_o, wd);
         else n_pass++;
         advance();
         hif.ex_start_i = 1'b0;
      end
      drive_idle();
   endtask

   task automatic test_ex_short();
      for (int c = 1; c >= 0; c--) begin
         hif.ex_start_i  = 1'b1;
         hif.ex_cycles_i = 6'(c);
         sample();
         n_checks++;
         if (hif.stall_o !== 6'b0 || hif.ex_done_o !== 1'b1)
            $display("FAIL ex_short n=%0d: got stall %b done %b want 000000 1", c, hif.stall_o,
                     hif.ex_done_o);
         else n_pass++;
         advance();
         drive_idle();
         sample();
         n_checks++;
         if (hif.ex_busy_o !== 1'b0 || hif.ex_done_o !== 1'b0)
            $display("FAIL ex_short_after n=%0d: got busy %b done %b want 0 0", c, hif.ex_busy_o,
                     hif.ex_done_o);
         else n_pass++;
         advance();
      end
   endtask

   task automatic test_br_deferred();
      for (int k = 0; k < 5; k++) begin
         logic [5:0] wf;
         hif.ex_start_i  = (k == 0);
         hif.ex_cycles_i = 6'd3;
         hif.br_flush_i  = (k == 1);
         wf = (k == 3) ? 6'b000110 : 6'b000000;
         sample();
         n_checks++;
         if (hif.flush_o !== wf) $display("FAIL br_deferred t+%0d: got %b want %b", k, hif.flush_o, wf);
         else n_pass++;
         advance();
      end
      drive_idle();
   endtask

   task automatic test_exception();
      for (int k = 0; k < 5; k++) begin
         hif.ex_start_i  = (k == 0);
         hif.ex_cycles_i = 6'd7;
         hif.br_flush_i  = (k == 0);
         hif.exc_flush_i = (k == 1);
         sample();
         if (k == 1) begin
            n_checks++;
            if (hif.flush_o !== 6'b111111 || hif.stall_o !== 6'b0 || hif.ex_busy_o !== 1'b1)
               $display("FAIL exc_flush: got flush %b stall %b busy %b want 111111 000000 1",
                        hif.flush_o, hif.stall_o, hif.ex_busy_o);
            else n_pass++;
         end
         if (k >= 2) begin
            n_checks++;
            if (hif.flush_o !== 6'b0 || hif.ex_busy_o !== 1'b0)
               $display("FAIL exc_after t+%0d: got flush %b busy %b want 000000 0", k, hif.flush_o,
                        hif.ex_busy_o);
            else n_pass++;
         end
         advance();
      end
      drive_idle();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rst                     = ($urandom_range(0, 49) == 0);
         hif.stallreq_from_if_i  = ($urandom_range(0, 3) == 0);
         hif.stallreq_from_id_i  = ($urandom_range(0, 3) == 0);
         hif.stallreq_from_mem_i = ($urandom_range(0, 4) == 0);
         hif.ex_start_i          = ($urandom_range(0, 3) == 0);
         hif.ex_cycles_i         = 6'($urandom_range(0, 9));
         hif.br_flush_i          = ($urandom_range(0, 6) == 0);
         hif.exc_flush_i         = ($urandom_range(0, 24) == 0);
         sample();
         n_checks++;
         if (hif.stall_o !== exp_stall || hif.flush_o !== exp_flush)
            $display("FAIL rnd_stall_flush it %0d: got %b/%b want %b/%b", i, hif.stall_o,
                     hif.flush_o, exp_stall, exp_flush);
         else n_pass++;
         n_checks++;
         if (hif.ex_busy_o !== exp_busy || hif.ex_done_o !== exp_done)
            $display("FAIL rnd_busy_done it %0d: got %b/%b want %b/%b", i, hif.ex_busy_o,
                     hif.ex_done_o, exp_busy, exp_done);
         else n_pass++;
         n_checks++;
         if (hif.stall_cycles_o !== exp_scnt || hif.flush_count_o !== exp_fcnt)
            $display("FAIL rnd_counters it %0d: got %0d/%0d want %0d/%0d", i, hif.stall_cycles_o,
                     hif.flush_count_o, exp_scnt, exp_fcnt);
         else n_pass++;
         advance();
      end
      rst = 1'b0;
      drive_idle();
   endtask

`ifdef PIPE_HAZARD_PERF_CNT_EN
   task automatic test_perf();
      rst = 1'b1;
      drive_idle();
      sample();
      advance();
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         hif.stallreq_from_id_i = (i < 7);
         hif.br_flush_i         = (i == 8 || i == 10);
         sample();
         advance();
      end
      drive_idle();
      sample();
      n_checks++;
      if (hif.stall_cycles_o !== 16'd7 || hif.flush_count_o !== 16'd2)
         $display("FAIL perf_count: got %0d/%0d want 7/2", hif.stall_cycles_o, hif.flush_count_o);
      else n_pass++;
      advance();
      hif.stallreq_from_id_i = 1'b1;
      for (int i = 0; i < 65540; i++) @(posedge clk);
      #1;
      n_checks++;
      if (hif.stall_cycles_o !== 16'hFFFF)
         $display("FAIL perf_saturate: got %h want ffff", hif.stall_cycles_o);
      else n_pass++;
      drive_idle();
   endtask
`endif

   initial begin
      rst = 1'b1;
      drive_idle();
      test_reset();
      test_id_mem_stall();
      test_ex_multi();
      test_ex_short();
      test_br_deferred();
      test_exception();
      test_random();
`ifdef PIPE_HAZARD_PERF_CNT_EN
      test_perf();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
